tick_scheduler: RTL

- Shared timebase controller for the calculator's slow-clock consumers: scan, debounce and blink logic.
- Holds NUM_CH independent programmable divider channels on the board clock.
- Each channel produces a one-cycle tick enable and a 50%-duty toggled clkout.
- Divide values are reconfigured at run time through a valid/ready port, sequenced by a small FSM so that a reload never produces a runt period.

---
 rtl/tick_sched_pkg.sv | 19 +
 rtl/tick_channel.sv | 59 +++++
 rtl/tick_scheduler.sv | 78 +++++++
 3 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler and its divider channels.
package tick_sched_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } sched_state_e;

  localparam int unsigned DEF_DIV0_C = 50000;
  localparam int unsigned DEF_DIV1_C = 25000;

  // Wide enough for any practical counter width; callers cast in and out.
  localparam int unsigned CLAMP_W = 64;

  function automatic logic [CLAMP_W-1:0] clamp_div(input logic [CLAMP_W-1:0] div);
    return (div == '0) ? CLAMP_W'(1) : div;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One programmable divider: counts 1..div, pulses tick and toggles clkout on wrap.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic [CNT_W-1:0] reset_div,
  output logic             tick,
  output logic             clkout
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  // A reload restarts the period and wins over a wrap in the same cycle.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (load) begin
      div_d = load_div;
      cnt_d = CNT_W'(1);
    end else if (run) begin
      if (cnt_q == div_q) begin
        cnt_d  = CNT_W'(1);
        clk_d  = ~clk_q;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      cnt_q  <= CNT_W'(1);
      div_q  <= reset_div;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign tick   = tick_q;
  assign clkout = clk_q;

endmodule

// File: rtl/tick_scheduler.sv
// Bank of divider channels with a two-state config FSM that reloads one channel at a time.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DEF_DIV0 = DEF_DIV0_C,
  parameter int unsigned DEF_DIV1 = DEF_DIV1_C,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clkout,
  output logic              busy
);

  sched_state_e     state_q, state_d;
  logic [CH_W-1:0]  ch_q;
  logic [CNT_W-1:0] div_q;
  logic             accept;
  logic [NUM_CH-1:0] load;

  assign accept = (state_q == S_IDLE) && cfg_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_valid) state_d = S_APPLY;
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The divide value is clamped at capture so channels only ever see div >= 1.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      div_q   <= CNT_W'(1);
    end else begin
      state_q <= state_d;
      if (accept) begin
        ch_q  <= cfg_ch;
        div_q <= CNT_W'(clamp_div(CLAMP_W'(cfg_div)));
      end
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_APPLY);

  // Out-of-range channel numbers match no decode line and are dropped.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign load[gi] = (state_q == S_APPLY) && (ch_q == CH_W'(gi));

      tick_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clkin     (clkin),
        .rst       (rst),
        .run       (run),
        .load      (load[gi]),
        .load_div  (div_q),
        .reset_div ((gi == 0) ? CNT_W'(DEF_DIV0) : CNT_W'(DEF_DIV1)),
        .tick      (tick[gi]),
        .clkout    (clkout[gi])
      );
    end
  endgenerate

endmodule
